// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared widths, iteration counts, FSM encoding and operand helpers for the RV64M sequencer.
package muldiv_ctrl_pkg;
  localparam int XLEN = 64;
  localparam int CNT_W = 7;
  localparam int ITER_D = 64;
  localparam int ITER_W = 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef struct packed {
    logic mul;
    logic word;
    logic neg_q;
    logic neg_r;
  } op_t;
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction
  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] d, input logic word, input logic sgn);
    return word ? {{(XLEN-32){sgn & d[31]}}, d[31:0]} : d;
  endfunction
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage request/response bundle between the pipeline (master) and the M-unit (slave).
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;
  logic flush;
  logic req_valid;
  logic mul_en;
  logic word;
  logic rs1_sign;
  logic rs2_sign;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic stall;
  logic result_valid;
  logic [XLEN-1:0] data_1;
  logic [XLEN-1:0] data_2;
  modport master (
    output flush, req_valid, mul_en, word, rs1_sign, rs2_sign, rs1_data, rs2_data,
    input  stall, result_valid, data_1, data_2
  );
  modport slave (
    input  flush, req_valid, mul_en, word, rs1_sign, rs2_sign, rs1_data, rs2_data,
    output stall, result_valid, data_1, data_2
  );
endinterface

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: radix-2 shift-add (mul, MSB-first) / restoring shift-subtract (div) datapath on magnitudes.
module muldiv_iter_dp
  import muldiv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  logic              mul,
  input  logic [XLEN-1:0]   sh_init,
  input  logic [XLEN-1:0]   b_init,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0]   sh_nxt
);
  logic [2*XLEN-1:0] acc, s;
  logic [XLEN-1:0] sh, b;
  logic [XLEN+1:0] t;
  // mul: acc is the running product; div: acc is the partial remainder, sh collects quotient bits
  always_comb begin
    s = (acc << 1) | {{(2*XLEN-1){1'b0}}, !mul & sh[XLEN-1]};
    t = {1'b0, s[XLEN:0]} - {2'b0, b};
    acc_nxt = mul ? s + (sh[XLEN-1] ? {{XLEN{1'b0}}, b} : '0)
                  : (t[XLEN+1] ? s : {{(XLEN-1){1'b0}}, t[XLEN:0]});
    sh_nxt = {sh[XLEN-2:0], !mul & !t[XLEN+1]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      sh <= '0;
      b <= '0;
    end else if (init) begin
      acc <= '0;
      sh <= sh_init;
      b <= b_init;
    end else if (step) begin
      acc <= acc_nxt;
      sh <= sh_nxt;
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV64M multiply/divide sequencer with pipeline stall and sign fix-up.
// Optional MULDIV_DIV0_FAST_EN: divide by zero skips the iterations and completes in one cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  muldiv_ctrl_if.slave bus
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  op_t op;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, sh_init, sh_nxt, quo, rem, res_1, res_2, data_1, data_2;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic neg_a, neg_b, div0, accept, step, last;
  always_comb begin
    a_ext = ext_op(bus.rs1_data, bus.word, bus.rs1_sign);
    b_ext = ext_op(bus.rs2_data, bus.word, bus.rs2_sign);
    neg_a = bus.rs1_sign & a_ext[XLEN-1];
    neg_b = bus.rs2_sign & b_ext[XLEN-1];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
    sh_init = bus.word ? mag_a << ITER_W : mag_a;
    div0 = !bus.mul_en & (b_ext == '0);
    accept = (state == IDLE) & bus.req_valid & !bus.flush;
    step = (state == CALC) & !bus.flush;
    last = cnt == (op.word ? CNT_W'(ITER_W - 1) : CNT_W'(ITER_D - 1));
    prod = op.neg_q ? -acc_nxt : acc_nxt;
    quo = op.neg_q ? -sh_nxt : sh_nxt;
    rem = op.neg_r ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    res_1 = op.mul ? prod[XLEN-1:0] : quo;
    res_2 = op.mul ? prod[2*XLEN-1:XLEN] : rem;
  end
  muldiv_iter_dp u_dp (
    .clk(clk),
    .rst(rst),
    .init(accept),
    .step(step),
    .mul(op.mul),
    .sh_init(sh_init),
    .b_init(mag_b),
    .acc_nxt(acc_nxt),
    .sh_nxt(sh_nxt)
  );
  assign bus.stall = !rst & (accept | (state == CALC));
  assign bus.result_valid = state == DONE;
  assign bus.data_1 = data_1;
  assign bus.data_2 = data_2;
  // quotient negation is dropped on divide by zero so it stays all ones
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      data_1 <= '0;
      data_2 <= '0;
    end else
      case (state)
        IDLE:
          if (accept) begin
            cnt <= '0;
            op <= '{mul: bus.mul_en, word: bus.word, neg_q: (neg_a ^ neg_b) & !div0, neg_r: neg_a};
`ifdef MULDIV_DIV0_FAST_EN
            state <= div0 ? DONE : CALC;
            if (div0) begin
              data_1 <= '1;
              data_2 <= bus.word ? sext32(a_ext[31:0]) : a_ext;
            end
`else
            state <= CALC;
`endif
          end
        CALC:
          if (bus.flush) state <= IDLE;
          else if (last) begin
            state <= DONE;
            data_1 <= op.word ? sext32(res_1[31:0]) : res_1;
            data_2 <= (op.word & !op.mul) ? sext32(res_2[31:0]) : res_2;
          end else cnt <= cnt + CNT_W'(1);
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table-driven vectors with a scoreboard queue, plus flush and reset sequences.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  muldiv_ctrl_if bus();
  muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef MULDIV_DIV0_FAST_EN
  localparam int Z_D = 1;
  localparam int Z_W = 1;
`else
  localparam int Z_D = 65;
  localparam int Z_W = 33;
`endif
  typedef struct {
    string nm;
    logic mul, word, s1, s2;
    logic [63:0] a, b, e1, e2;
    logic chk2;
    int lat;
  } vec_t;
  typedef struct {
    logic [63:0] e1, e2;
    logic chk2;
    int lat;
  } exp_t;
  vec_t vt[14];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v, input logic push);
    bus.mul_en = v.mul;
    bus.word = v.word;
    bus.rs1_sign = v.s1;
    bus.rs2_sign = v.s2;
    bus.rs1_data = v.a;
    bus.rs2_data = v.b;
    bus.req_valid = 1;
    if (push) sb.push_back('{v.e1, v.e2, v.chk2, v.lat});
    #1 chk({v.nm, " stall at accept"}, 64'(bus.stall), 64'd1);
  endtask
  task automatic collect(input string nm);
    exp_t e;
    int lat;
    @(negedge clk);
    bus.req_valid = 0;
    bus.rs1_data = {$urandom, $urandom};
    bus.rs2_data = {$urandom, $urandom};
    lat = 1;
    e = sb.pop_front();
    chk({nm, " stall after accept"}, 64'(bus.stall), 64'(e.lat > 1));
    while (!bus.result_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(e.lat));
    chk({nm, " data_1"}, bus.data_1, e.e1);
    if (e.chk2) chk({nm, " data_2"}, bus.data_2, e.e2);
    chk({nm, " stall at valid"}, 64'(bus.stall), 64'd0);
  endtask
  initial begin
    automatic logic ok;
    vt[0]  = '{"mul",     1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFF, 1, 65};
    vt[1]  = '{"mulhu",   1, 0, 0, 0, '1, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 65};
    vt[2]  = '{"divu",    0, 0, 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 1, 65};
    vt[3]  = '{"div",     0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1, 65};
    vt[4]  = '{"div ovf", 0, 0, 1, 1, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 1, 65};
    vt[5]  = '{"div0",    0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, '1, 64'hFFFF_FFFF_FFFF_FFFB, 1, Z_D};
    vt[6]  = '{"mulw",    1, 1, 1, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 0, 33};
    vt[7]  = '{"divw ovf", 0, 1, 1, 1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1, 33};
    vt[8]  = '{"divuw0",  0, 1, 0, 0, 64'h1234_5678_0000_0007, 64'hABCD_0000_0000_0000, '1, 64'd7, 1, Z_W};
    vt[9]  = '{"mulh",    1, 0, 1, 1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'h4000_0000_0000_0000, 1, 65};
    vt[10] = '{"mulhsu",  1, 0, 1, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1, 65};
    vt[11] = '{"rem",     0, 0, 1, 1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1, 65};
    vt[12] = '{"divuw",   0, 1, 0, 0, 64'hFFFF_FFF0, 64'd3, 64'h5555_5550, 64'd0, 1, 33};
    vt[13] = '{"mulu 2^64", 1, 0, 0, 0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd1, 1, 65};
    bus.flush = 0;
    bus.mul_en = 0;
    bus.word = 0;
    bus.rs1_sign = 0;
    bus.rs2_sign = 0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.req_valid = 1;
    #2;
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset valid", 64'(bus.result_valid), 64'd0);
    chk("reset data_1", bus.data_1, 64'd0);
    chk("reset data_2", bus.data_2, 64'd0);
    @(negedge clk);
    rst = 0;
    bus.req_valid = 0;
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i], 1);
      collect(vt[i].nm);
    end
    // flush at T+10 aborts a multiply; a request at T+11 is accepted
    @(negedge clk);
    drive(vt[0], 0);
    @(negedge clk);
    bus.req_valid = 0;
    ok = 1;
    for (int k = 1; k < 10; k++) begin
      if (bus.result_valid || !bus.stall) ok = 0;
      @(negedge clk);
    end
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    chk("calc stall before flush", 64'(ok), 64'd1);
    chk("flush stall", 64'(bus.stall), 64'd0);
    chk("flush valid", 64'(bus.result_valid), 64'd0);
    drive(vt[2], 1);
    collect("after flush");
    // request together with flush in IDLE is not accepted
    @(negedge clk);
    bus.mul_en = 0;
    bus.req_valid = 1;
    bus.flush = 1;
    #1 chk("req+flush stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.req_valid = 0;
    bus.flush = 0;
    #1 chk("req+flush not accepted", 64'(bus.stall), 64'd0);
    // reset pulse in the middle of a calculation
    @(negedge clk);
    drive(vt[1], 0);
    @(negedge clk);
    bus.req_valid = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    chk("mid rst stall", 64'(bus.stall), 64'd0);
    chk("mid rst valid", 64'(bus.result_valid), 64'd0);
    chk("mid rst data_1", bus.data_1, 64'd0);
    chk("mid rst data_2", bus.data_2, 64'd0);
    @(negedge clk);
    rst = 0;
    ok = 1;
    repeat (80) begin
      @(negedge clk);
      if (bus.result_valid || bus.stall) ok = 0;
    end
    chk("idle after rst", 64'(ok), 64'd1);
    @(negedge clk);
    drive(vt[3], 1);
    collect("after rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
